// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared register map, bit indices and frame constants
package ps2_pkg;

  typedef enum logic [1:0] {
    REG_DATA   = 2'd0,
    REG_STATUS = 2'd1,
    REG_CTRL   = 2'd2,
    REG_NONE   = 2'd3
  } reg_sel_e;

  localparam logic [3:0] OFF_DATA   = 4'h0;
  localparam logic [3:0] OFF_STATUS = 4'h4;
  localparam logic [3:0] OFF_CTRL   = 4'h8;

  localparam int ST_EMPTY     = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_OVERFLOW  = 2;
  localparam int ST_PARITY    = 3;
  localparam int ST_FRAME     = 4;
  localparam int ST_TIMEOUT   = 5;
  localparam int ST_COUNT_LSB = 8;

  localparam int CTRL_RX_EN  = 0;
  localparam int CTRL_IRQ_EN = 1;

  localparam int FRAME_BITS = 11;

  function automatic reg_sel_e decode_reg(input logic [3:0] off);
    case (off)
      OFF_DATA:   return REG_DATA;
      OFF_STATUS: return REG_STATUS;
      OFF_CTRL:   return REG_CTRL;
      default:    return REG_NONE;
    endcase
  endfunction

endpackage

// File: rtl/ps2_rx_fifo.sv
// rtl/ps2_rx_fifo.sv - receive byte FIFO with occupancy count
module ps2_rx_fifo #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        push,
  input  logic                        pop,
  input  logic [7:0]                  din,
  output logic [7:0]                  dout,
  output logic                        empty,
  output logic                        full,
  output logic [$clog2(FIFO_DEPTH):0] count
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(FIFO_DEPTH));
  assign do_pop  = pop & ~empty;
  // a pop in the same cycle frees the slot a full-FIFO push needs
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_rx_apb_v2.sv
// rtl/ps2_rx_apb_v2.sv - PS/2 receiver with APB register interface and FIFO
module ps2_rx_apb_v2
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 16,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] in_paddr,
  input  logic        in_psel,
  input  logic        in_penable,
  input  logic        in_pwrite,
  input  logic [2:0]  in_pprot,
  input  logic [31:0] in_pwdata,
  input  logic [3:0]  in_pstrb,
  output logic        in_pready,
  output logic [31:0] in_prdata,
  output logic        in_pslverr,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic        irq
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  logic          clk_s1, clk_s2, clk_s3, dat_s1, dat_s2;
  logic          fall;
  logic [3:0]    bit_cnt;
  logic [FRAME_BITS-2:0] shreg;
  logic [TW-1:0] idle_cnt;
  logic [1:0]    ctrl;
  logic [3:0]    sticky;
  logic          rx_en;
  logic          frame_end, start_ok, stop_ok, par_ok, good;
  logic          set_frm, set_par, set_ovf, timeout_hit;
  logic          access, err, pop, st_wr, ctrl_wr;
  logic [3:0]    w1c;
  reg_sel_e      sel;
  logic [7:0]    dout;
  logic          empty, full;
  logic [CW-1:0] count;
  logic [31:0]   status_w;
  logic          unused;

  assign unused = ^{in_pprot, in_paddr[31:4], in_paddr[1:0], in_pstrb[3:1], in_pwdata[31:6]};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      {clk_s1, clk_s2, clk_s3, dat_s1, dat_s2} <= '1;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      clk_s3 <= clk_s2;
      dat_s1 <= ps2_data;
      dat_s2 <= dat_s1;
    end
  end

  assign fall  = clk_s3 & ~clk_s2;
  assign rx_en = ctrl[CTRL_RX_EN];

  // shreg holds start..parity with the start bit at [0] once 10 bits are in
  assign frame_end   = rx_en & fall & (bit_cnt == 4'(FRAME_BITS - 1));
  assign start_ok    = ~shreg[0];
  assign stop_ok     = dat_s2;
  assign par_ok      = ^shreg[9:1];
  assign good        = frame_end & start_ok & stop_ok & par_ok;
  assign set_frm     = frame_end & ~(start_ok & stop_ok);
  assign set_par     = frame_end & start_ok & stop_ok & ~par_ok;
  assign set_ovf     = good & full & ~pop;
  assign timeout_hit = (bit_cnt != 4'd0) & ~fall & (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bit_cnt <= '0;
      shreg   <= '0;
    end else if (!rx_en) begin
      bit_cnt <= '0;
    end else if (fall) begin
      if (frame_end) begin
        bit_cnt <= '0;
      end else begin
        bit_cnt <= bit_cnt + 4'd1;
        shreg   <= {dat_s2, shreg[FRAME_BITS-2:1]};
      end
    end else if (timeout_hit) begin
      bit_cnt <= '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                                    idle_cnt <= '0;
    else if (fall)                                idle_cnt <= '0;
    else if (idle_cnt != TW'(TIMEOUT_CYCLES - 1)) idle_cnt <= idle_cnt + 1'b1;
  end

  assign sel        = decode_reg({in_paddr[3:2], 2'b00});
  assign access     = in_psel & in_penable;
  assign err        = (sel == REG_NONE) | ((sel == REG_DATA) & in_pwrite);
  assign in_pready  = access;
  assign in_pslverr = access & err;
  assign pop        = access & ~in_pwrite & (sel == REG_DATA) & ~empty;
  assign st_wr      = access & in_pwrite & (sel == REG_STATUS) & in_pstrb[0];
  assign ctrl_wr    = access & in_pwrite & (sel == REG_CTRL) & in_pstrb[0];
  assign w1c        = st_wr ? in_pwdata[ST_TIMEOUT:ST_OVERFLOW] : 4'b0;

  // sticky = {timeout, frame_err, parity_err, overflow}; hardware set beats W1C
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sticky <= '0;
      ctrl   <= 2'b01;
      irq    <= 1'b0;
    end else begin
      sticky <= (sticky & ~w1c) | {timeout_hit, set_frm, set_par, set_ovf};
      if (ctrl_wr) ctrl <= in_pwdata[1:0];
      irq <= ctrl[CTRL_IRQ_EN] & (~empty | (|sticky));
    end
  end

  always_comb begin
    status_w                        = '0;
    status_w[ST_EMPTY]              = empty;
    status_w[ST_FULL]               = full;
    status_w[ST_TIMEOUT:ST_OVERFLOW] = sticky;
    status_w[ST_COUNT_LSB +: CW]    = count;
  end

  always_comb begin
    in_prdata = '0;
    if (access) begin
      case (sel)
        REG_DATA:   in_prdata = empty ? 32'h0 : {23'b0, 1'b1, dout};
        REG_STATUS: in_prdata = status_w;
        REG_CTRL:   in_prdata = {30'b0, ctrl};
        default:    in_prdata = '0;
      endcase
    end
  end

  ps2_rx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (good),
    .pop   (pop),
    .din   (shreg[8:1]),
    .dout  (dout),
    .empty (empty),
    .full  (full),
    .count (count)
  );

endmodule

// File: tb/tb_ps2_rx_apb_v2.sv
// tb/tb_ps2_rx_apb_v2.sv - self-checking bench for ps2_rx_apb_v2
module tb_ps2_rx_apb_v2;

  localparam int DEPTH = 4;
  localparam int TMO   = 100;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] in_paddr = '0;
  logic        in_psel = 1'b0, in_penable = 1'b0, in_pwrite = 1'b0;
  logic [2:0]  in_pprot = '0;
  logic [31:0] in_pwdata = '0;
  logic [3:0]  in_pstrb = '0;
  logic        in_pready, in_pslverr, irq;
  logic [31:0] in_prdata;
  logic        ps2_clk = 1'b1, ps2_data = 1'b1;

  int total = 0;
  int bad   = 0;

  byte unsigned mq[$];
  logic m_ovf = 0, m_par = 0, m_frm = 0, m_tmo = 0;
  logic [1:0] m_ctrl = 2'b01;

  ps2_rx_apb_v2 #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clock(clock), .reset(reset), .in_paddr(in_paddr), .in_psel(in_psel),
    .in_penable(in_penable), .in_pwrite(in_pwrite), .in_pprot(in_pprot),
    .in_pwdata(in_pwdata), .in_pstrb(in_pstrb), .in_pready(in_pready),
    .in_prdata(in_prdata), .in_pslverr(in_pslverr), .ps2_clk(ps2_clk),
    .ps2_data(ps2_data), .irq(irq)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_status();
    return {16'b0, 8'(mq.size()), 2'b0, m_tmo, m_frm, m_par, m_ovf,
            (mq.size() == DEPTH), (mq.size() == 0)};
  endfunction

  function automatic logic m_irq();
    return m_ctrl[1] & ((mq.size() != 0) | m_ovf | m_par | m_frm | m_tmo);
  endfunction

  task automatic apb(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] strb, output logic [31:0] rdata,
                     output logic err, output logic rdy);
    @(negedge clock);
    in_psel = 1; in_penable = 0; in_pwrite = wr; in_paddr = addr;
    in_pwdata = wdata; in_pstrb = strb;
    @(negedge clock);
    in_penable = 1;
    #1;
    rdata = in_prdata; err = in_pslverr; rdy = in_pready;
    @(posedge clock);
    #1;
    in_psel = 0; in_penable = 0; in_pwrite = 0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    logic [31:0] r; logic e, y;
    apb(1'b1, addr, data, strb, r, e, y);
    if (strb[0] && addr == 32'h4) begin
      if (data[2]) m_ovf = 0;
      if (data[3]) m_par = 0;
      if (data[4]) m_frm = 0;
      if (data[5]) m_tmo = 0;
    end
    if (strb[0] && addr == 32'h8) m_ctrl = data[1:0];
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] r; logic e, y;
    apb(1'b0, addr, 32'h0, 4'h0, r, e, y);
    chk(tag, r, exp);
  endtask

  task automatic rd_data(input string tag);
    logic [31:0] exp;
    exp = 32'h0;
    if (mq.size() > 0) exp = {23'b0, 1'b1, mq.pop_front()};
    rd_chk(tag, 32'h0, exp);
  endtask

  function automatic logic [10:0] mkframe(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    logic p;
    p = ~(^b) ^ bad_par;
    return {~bad_stop, p, b, 1'b0};
  endfunction

  task automatic ps2_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      ps2_data = f[i];
      repeat (5) @(negedge clock);
      ps2_clk = 0;
      repeat (10) @(negedge clock);
      ps2_clk = 1;
      repeat (5) @(negedge clock);
    end
    ps2_data = 1;
  endtask

  task automatic model_frame(input logic [7:0] b, input bit bp, input bit bs);
    if (m_ctrl[0]) begin
      if (bs)                      m_frm = 1;
      else if (bp)                 m_par = 1;
      else if (mq.size() < DEPTH)  mq.push_back(b);
      else                         m_ovf = 1;
    end
  endtask

  task automatic send(input logic [7:0] b, input bit bp, input bit bs);
    ps2_bits(mkframe(b, bp, bs), 11);
    repeat (4) @(negedge clock);
    model_frame(b, bp, bs);
  endtask

  initial begin
    logic [31:0] r;
    logic e, y;
    logic [10:0] f;
    logic [7:0] b;
    int k;

    #23;
    chk("reset_irq", {31'b0, irq}, 32'h0);
    chk("reset_prdata", in_prdata, 32'h0);
    chk("reset_pready", {31'b0, in_pready}, 32'h0);
    @(negedge clock);
    reset = 0;
    rd_chk("reset_status", 32'h4, 32'h1);
    rd_chk("reset_ctrl", 32'h8, 32'h1);
    rd_chk("reset_data", 32'h0, 32'h0);

    send(8'h1C, 0, 0);
    rd_chk("rx_1c", 32'h0, 32'h0000011C);
    mq.delete();
    rd_chk("rx_1c_again", 32'h0, 32'h0);
    rd_chk("rx_1c_status", 32'h4, 32'h1);

    apb(1'b0, 32'hC, 32'h0, 4'h0, r, e, y);
    chk("unmapped_err", {31'b0, e}, 32'h1);
    chk("unmapped_rdy", {31'b0, y}, 32'h1);
    send(8'hA7, 0, 0);
    apb(1'b1, 32'h0, 32'hFF, 4'hF, r, e, y);
    chk("wr_data_err", {31'b0, e}, 32'h1);
    rd_chk("wr_data_noeffect", 32'h4, m_status());
    rd_data("wr_data_byte");

    wr(32'h8, 32'h0, 4'h0);
    rd_chk("strb0_ctrl", 32'h8, 32'h1);

    send(8'h55, 1, 0);
    rd_chk("parity_status", 32'h4, m_status());
    wr(32'h4, 32'h8, 4'h1);
    rd_chk("parity_w1c", 32'h4, m_status());

    for (int i = 0; i < 5; i++) send(8'($urandom), 0, 0);
    rd_chk("ovf_status", 32'h4, m_status());
    for (int i = 0; i < 4; i++) rd_data("ovf_order");
    wr(32'h4, 32'h4, 4'h1);
    rd_chk("ovf_clear", 32'h4, m_status());

    ps2_bits(mkframe(8'h12, 0, 0), 4);
    repeat (150) @(negedge clock);
    m_tmo = 1;
    rd_chk("timeout_status", 32'h4, m_status());
    send(8'hF0, 0, 0);
    rd_chk("timeout_next", 32'h0, 32'h000001F0);
    mq.delete();
    wr(32'h4, 32'h20, 4'h1);

    wr(32'h8, 32'h0, 4'h1);
    send(8'h33, 0, 0);
    rd_chk("rxdis_status", 32'h4, m_status());
    wr(32'h8, 32'h1, 4'h1);

    ps2_bits(mkframe(8'h77, 0, 0), 5);
    wr(32'h8, 32'h0, 4'h1);
    wr(32'h8, 32'h1, 4'h1);
    send(8'h42, 0, 0);
    rd_chk("abort_status", 32'h4, m_status());
    rd_data("abort_next");

    wr(32'h8, 32'h3, 4'h1);
    f = mkframe(8'h29, 0, 0);
    ps2_bits(f, 10);
    @(negedge clock);
    ps2_data = f[10];
    repeat (5) @(negedge clock);
    ps2_clk = 0;
    repeat (3) @(posedge clock);
    #1;
    chk("irq_before", {31'b0, irq}, 32'h0);
    @(posedge clock);
    #1;
    chk("irq_after_push", {31'b0, irq}, 32'h1);
    repeat (6) @(negedge clock);
    ps2_clk = 1;
    repeat (5) @(negedge clock);
    ps2_data = 1;
    model_frame(8'h29, 0, 0);
    rd_data("irq_data");
    chk("irq_hold", {31'b0, irq}, 32'h1);
    @(posedge clock);
    #1;
    chk("irq_drop", {31'b0, irq}, 32'h0);

    for (int i = 0; i < 24; i++) begin
      b = 8'($urandom);
      k = int'($urandom_range(0, 5));
      send(b, k == 4, k == 5);
      for (int j = int'($urandom_range(0, 2)); j > 0; j--) rd_data("rand_data");
      if ($urandom_range(0, 3) == 0) wr(32'h4, {26'b0, 4'($urandom), 2'b0}, 4'h1);
      rd_chk("rand_status", 32'h4, m_status());
      chk("rand_irq", {31'b0, irq}, {31'b0, m_irq()});
    end

    send(8'h99, 0, 0);
    repeat (2) @(negedge clock);
    chk("pre_reset_irq", {31'b0, irq}, {31'b0, m_irq()});
    ps2_bits(mkframe(8'h66, 0, 0), 5);
    @(negedge clock);
    ps2_clk = 0;
    #2;
    reset = 1;
    #1;
    chk("midreset_irq", {31'b0, irq}, 32'h0);
    chk("midreset_prdata", in_prdata, 32'h0);
    chk("midreset_pslverr", {31'b0, in_pslverr}, 32'h0);
    ps2_clk = 1;
    repeat (3) @(negedge clock);
    reset = 0;
    mq.delete();
    m_ovf = 0; m_par = 0; m_frm = 0; m_tmo = 0; m_ctrl = 2'b01;
    rd_chk("postreset_ctrl", 32'h8, 32'h1);
    rd_chk("postreset_status", 32'h4, 32'h1);
    rd_chk("postreset_data", 32'h0, 32'h0);
    send(8'h5A, 0, 0);
    rd_chk("postreset_rx", 32'h0, 32'h0000015A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
